// File: rtl/sumador_pkg.sv
// Shared definitions for the 32-bit adder monitor: operation encodings,
// widths, tracking-state type and a saturating counter helper.
package sumador_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        MODO_HOLD  = 2'b00,
        MODO_SUMA  = 2'b01,
        MODO_RESTA = 2'b10,
        MODO_CLR   = 2'b11
    } modo_e;

    typedef enum logic {
        ST_SYNC  = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == {CNT_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/monitor_sumador32_if.sv
// Bundle of adder-observation inputs and monitor status outputs.
// master = adder/environment side, slave = monitor side.
interface monitor_sumador32_if;
    import sumador_pkg::*;

    logic              ENB;
    logic [1:0]        MODO;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              RCI;
    logic [DATA_W-1:0] Q;
    logic              RCO;
    logic              CHK_EN;
    logic              CLR_ERR;
    logic [DATA_W-1:0] EXP_Q;
    logic              EXP_RCO;
    logic              SYNCED;
    logic              ERR;
    logic              ERR_STICKY;
    logic [CNT_W-1:0]  ERR_COUNT;
    logic [CNT_W-1:0]  CHK_COUNT;

    modport master (
        output ENB, MODO, A, B, RCI, Q, RCO, CHK_EN, CLR_ERR,
        input  EXP_Q, EXP_RCO, SYNCED, ERR, ERR_STICKY, ERR_COUNT, CHK_COUNT
    );

    modport slave (
        input  ENB, MODO, A, B, RCI, Q, RCO, CHK_EN, CLR_ERR,
        output EXP_Q, EXP_RCO, SYNCED, ERR, ERR_STICKY, ERR_COUNT, CHK_COUNT
    );

endinterface

// File: rtl/modelo_sumador32.sv
// Reference model of the adder: holds the expected {carry, result} pair and
// applies the same operation the adder is asked to perform on each enabled edge.
module modelo_sumador32
    import sumador_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic [1:0]        modo,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              rci,
    output logic [DATA_W-1:0] exp_q,
    output logic              exp_rco
);

    logic [DATA_W-1:0] exp_q_d, exp_q_q;
    logic              exp_rco_d, exp_rco_q;
    logic [DATA_W:0]   sum_s;
    logic [DATA_W:0]   diff_s;

    // Next expected value; subtraction borrow appears as the extended top bit.
    always_comb begin
        exp_q_d   = exp_q_q;
        exp_rco_d = exp_rco_q;
        sum_s     = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, rci};
        diff_s    = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, rci};
        if (enb) begin
            case (modo_e'(modo))
                MODO_HOLD: begin
                    exp_q_d   = exp_q_q;
                    exp_rco_d = exp_rco_q;
                end
                MODO_SUMA: begin
                    exp_q_d   = sum_s[DATA_W-1:0];
                    exp_rco_d = sum_s[DATA_W];
                end
                MODO_RESTA: begin
                    exp_q_d   = diff_s[DATA_W-1:0];
                    exp_rco_d = diff_s[DATA_W];
                end
                MODO_CLR: begin
                    exp_q_d   = {DATA_W{1'b0}};
                    exp_rco_d = 1'b0;
                end
                default: begin
                    exp_q_d   = exp_q_q;
                    exp_rco_d = exp_rco_q;
                end
            endcase
        end else begin
            exp_q_d   = exp_q_q;
            exp_rco_d = exp_rco_q;
        end
    end

    // Expected-result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q_q   <= {DATA_W{1'b0}};
            exp_rco_q <= 1'b0;
        end else begin
            exp_q_q   <= exp_q_d;
            exp_rco_q <= exp_rco_d;
        end
    end

    assign exp_q   = exp_q_q;
    assign exp_rco = exp_rco_q;

endmodule

// File: rtl/monitor_sumador32.sv
// Online checker for a 32-bit registered adder: tracks the expected result,
// compares the observed output one cycle later and keeps error statistics.
module monitor_sumador32
    import sumador_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    monitor_sumador32_if.slave   bus
);

    logic [DATA_W-1:0] exp_q_s;
    logic              exp_rco_s;
    state_e            state_d, state_q;
    logic              err_d, err_q;
    logic              sticky_d, sticky_q;
    logic [CNT_W-1:0]  err_count_d, err_count_q;
    logic [CNT_W-1:0]  chk_count_d, chk_count_q;
    logic [CNT_W-1:0]  err_base_s, chk_base_s;
    logic              cmp_s, mis_s;

    modelo_sumador32 u_modelo (
        .clk     (CLK),
        .reset   (RESET),
        .enb     (bus.ENB),
        .modo    (bus.MODO),
        .a       (bus.A),
        .b       (bus.B),
        .rci     (bus.RCI),
        .exp_q   (exp_q_s),
        .exp_rco (exp_rco_s)
    );

    // Compare against the value held since the previous edge; a same-edge
    // comparison wins over CLR_ERR by counting on top of a zeroed base.
    always_comb begin
        cmp_s      = (state_q == ST_TRACK) && bus.CHK_EN;
        mis_s      = cmp_s && ({bus.RCO, bus.Q} != {exp_rco_s, exp_q_s});
        err_d      = mis_s;
        chk_base_s = bus.CLR_ERR ? {CNT_W{1'b0}} : chk_count_q;
        err_base_s = bus.CLR_ERR ? {CNT_W{1'b0}} : err_count_q;
        if (cmp_s) begin
            chk_count_d = sat_inc(chk_base_s);
        end else begin
            chk_count_d = chk_base_s;
        end
        if (mis_s) begin
            err_count_d = sat_inc(err_base_s);
            sticky_d    = 1'b1;
        end else begin
            err_count_d = err_base_s;
            sticky_d    = bus.CLR_ERR ? 1'b0 : sticky_q;
        end
        if ((state_q == ST_SYNC) && bus.ENB && (bus.MODO != MODO_HOLD)) begin
            state_d = ST_TRACK;
        end else begin
            state_d = state_q;
        end
    end

    // State, status and counter registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_SYNC;
            err_q       <= 1'b0;
            sticky_q    <= 1'b0;
            err_count_q <= {CNT_W{1'b0}};
            chk_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            sticky_q    <= sticky_d;
            err_count_q <= err_count_d;
            chk_count_q <= chk_count_d;
        end
    end

    assign bus.EXP_Q      = exp_q_s;
    assign bus.EXP_RCO    = exp_rco_s;
    assign bus.SYNCED     = (state_q == ST_TRACK);
    assign bus.ERR        = err_q;
    assign bus.ERR_STICKY = sticky_q;
    assign bus.ERR_COUNT  = err_count_q;
    assign bus.CHK_COUNT  = chk_count_q;

endmodule

// File: doc/monitor_sumador32.md
MONITOR_SUMADOR32 -- requirements
Module: monitor_sumador32

Interface
REQ-001 SHALL have port CLK  in  1  single rising-edge clock for all state.
REQ-002 SHALL have port RESET  in  1  synchronous, active-high reset, sampled on rising CLK.
REQ-003 SHALL have ports ENB  in  1, MODO  in  2, A  in  32, B  in  32, RCI  in  1: adder controls and operands, observed at the same edges as the adder.
REQ-004 SHALL have ports Q  in  32 and RCO  in  1: adder result and carry/borrow under observation.
REQ-005 SHALL have port CHK_EN  in  1  enabling comparison.
REQ-006 SHALL have port CLR_ERR  in  1  clearing error state.
REQ-007 SHALL have ports EXP_Q  out  32 and EXP_RCO  out  1: registered expected result.
REQ-008 SHALL have port SYNCED  out  1  high when the model tracks the adder.
REQ-009 SHALL have ports ERR  out  1 (one-cycle mismatch pulse) and ERR_STICKY  out  1.
REQ-010 SHALL have ports ERR_COUNT  out  16 and CHK_COUNT  out  16: saturating counters.

Function
REQ-011 SHALL update the model on each rising CLK only when ENB=1: MODO 00 holds, 01 sets {EXP_RCO,EXP_Q}=A+B+RCI (33-bit), 10 sets EXP_Q=A-B-RCI mod 2^32 with EXP_RCO=1 iff borrow, 11 clears EXP_Q and EXP_RCO to 0.
REQ-012 SHALL hold the model unchanged when ENB=0, regardless of MODO.
REQ-013 SHALL implement FSM states SYNC and TRACK; RESET forces SYNC.
REQ-014 SHALL move SYNC->TRACK at an edge with ENB=1 and MODO!=00; TRACK is left only by RESET.
REQ-015 SHALL drive SYNCED=1 exactly when state is TRACK.
REQ-016 SHALL compare at edge k, when state=TRACK and CHK_EN=1, sampled Q/RCO against EXP_Q/EXP_RCO held since edge k-1 (pre-update values); latency one cycle, matching the adder.
REQ-017 SHALL, for each such comparison, increment CHK_COUNT and set ERR for one cycle on mismatch of any Q bit or RCO.
REQ-018 SHALL, on mismatch, increment ERR_COUNT and set ERR_STICKY.
REQ-019 SHALL saturate both counters at 16'hFFFF, never wrapping.
REQ-020 SHALL perform no comparison in SYNC, at the transition edge, or when CHK_EN=0; ERR=0 then.
REQ-021 SHALL, on CLR_ERR=1, zero ERR_COUNT, CHK_COUNT and ERR_STICKY; a comparison at the same edge takes priority: counters load 1 (or 0 if no mismatch), sticky set on mismatch.
REQ-022 SHALL not let CLR_ERR affect the model or FSM state.

Reset
REQ-023 SHALL, on RESET=1 at a rising edge, set EXP_Q=0, EXP_RCO=0, state=SYNC, SYNCED=0, ERR=0, ERR_STICKY=0, ERR_COUNT=0, CHK_COUNT=0.
REQ-024 SHALL give RESET priority over CLR_ERR, ENB and every other input, including mid-sequence.

Structure
REQ-025 SHALL place MODO encodings (MODO_HOLD=00, MODO_SUMA=01, MODO_RESTA=10, MODO_CLR=11), data width 32, counter width 16 and the FSM state type in shared package sumador_pkg.
REQ-026 SHALL isolate the expected-result register and arithmetic in sub-module modelo_sumador32; comparison, FSM and counters stay in monitor_sumador32.

Verification
REQ-027 SHALL cover: RESET, MODO=11 ENB=1, then MODO=01 A=17 B=3 RCI=0 -> EXP_Q=20, EXP_RCO=0; correct Q -> ERR=0, CHK_COUNT increments.
REQ-028 SHALL cover: MODO=01 A=1 B=32'hFFFFFFFF -> EXP_Q=0, EXP_RCO=1; then MODO=10 A=3 B=8 -> EXP_Q=32'hFFFFFFFB, EXP_RCO=1.
REQ-029 SHALL cover: MODO=01 A=5 B=3, then MODO=00 for 3 cycles, then ENB=0 with MODO=10 A=3 B=1 -> EXP_Q stays 8 throughout.
REQ-030 SHALL cover: forced Q=21 while EXP_Q=20 -> ERR pulse one cycle, ERR_STICKY=1, ERR_COUNT=1; CLR_ERR then clears both counters and sticky.
REQ-031 SHALL cover: ERR_COUNT preset near 16'hFFFF via sustained mismatch -> holds 16'hFFFF; RESET mid-run -> all outputs zero, SYNCED=0, no ERR until next non-hold op.
